// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving a single-port S-box RAM; define KSA_SKIP_SELF_SWAP_EN to skip i==j swaps.
// Iteration takes 2*(RD_LATENCY+1)+2 cycles; no backpressure, start is edge-triggered and abort cancels a run.
module rc4_ksa_engine #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 8,
  parameter int MAX_KEY_BYTES = 16,
  parameter int RD_LATENCY    = 1,
  parameter int START_INDEX   = 0,
  parameter int END_INDEX     = 2**ADDR_W-1,
  localparam int LEN_W        = $clog2(MAX_KEY_BYTES+1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [MAX_KEY_BYTES*DATA_W-1:0] key,
  input  logic [LEN_W-1:0]                key_len,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wdata,
  output logic                            ram_we,
  input  logic [DATA_W-1:0]               ram_rdata
);

  localparam int KIDX_W = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
  localparam int CNT_W  = $clog2(RD_LATENCY+1);
  localparam int SUM_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  typedef enum logic [2:0] {IDLE, READ_I, READ_J, WRITE_I, WRITE_J, FINISH} state_t;

  state_t                                  state_q;
  logic [ADDR_W-1:0]                       i_q, j_q;
  logic [KIDX_W-1:0]                       k_q;
  logic [LEN_W-1:0]                        len_q;
  logic [MAX_KEY_BYTES-1:0][DATA_W-1:0]    key_q;
  logic [DATA_W-1:0]                       si_q;
  logic [CNT_W-1:0]                        cnt_q;
  logic                                    start_q;
  logic                                    busy_q, done_q, we_q;
  logic [ADDR_W-1:0]                       addr_q;
  logic [DATA_W-1:0]                       wdata_q;

  logic [LEN_W-1:0]  len_d;
  logic [SUM_W-1:0]  sum_d;
  logic [ADDR_W-1:0] j_new_d;
  logic [KIDX_W-1:0] k_next_d;
  logic              k_last, i_last, rd_last, start_edge;

  assign start_edge = start & ~start_q;
  assign len_d   = (key_len == '0 || key_len > LEN_W'(MAX_KEY_BYTES)) ? LEN_W'(MAX_KEY_BYTES) : key_len;
  // Widen every operand before the add, then keep only the address bits.
  assign sum_d   = SUM_W'(j_q) + SUM_W'(ram_rdata) + SUM_W'(key_q[k_q]);
  assign j_new_d = sum_d[ADDR_W-1:0];
  // Key index wraps by comparison against the latched length instead of a modulo.
  assign k_last   = (LEN_W'(k_q) + LEN_W'(1)) == len_q;
  assign k_next_d = k_last ? '0 : k_q + KIDX_W'(1);
  assign i_last   = (i_q == ADDR_W'(END_INDEX));
  assign rd_last  = (cnt_q == CNT_W'(RD_LATENCY));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= ADDR_W'(START_INDEX);
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      key_q   <= '0;
      si_q    <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      start_q <= start;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        we_q    <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            if (start_edge) begin
              key_q   <= key;
              len_q   <= len_d;
              i_q     <= ADDR_W'(START_INDEX);
              j_q     <= '0;
              k_q     <= '0;
              cnt_q   <= '0;
              addr_q  <= ADDR_W'(START_INDEX);
              busy_q  <= 1'b1;
              state_q <= READ_I;
            end
          end
          READ_I: begin
            if (!rd_last) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q <= '0;
              si_q  <= ram_rdata;
              j_q   <= j_new_d;
`ifdef KSA_SKIP_SELF_SWAP_EN
              if (j_new_d == i_q) begin
                k_q <= k_next_d;
                if (i_last) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FINISH;
                end else begin
                  i_q    <= i_q + ADDR_W'(1);
                  addr_q <= i_q + ADDR_W'(1);
                end
              end else begin
                addr_q  <= j_new_d;
                state_q <= READ_J;
              end
`else
              addr_q  <= j_new_d;
              state_q <= READ_J;
`endif
            end
          end
          READ_J: begin
            if (!rd_last) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q   <= '0;
              addr_q  <= i_q;
              wdata_q <= ram_rdata;
              we_q    <= 1'b1;
              state_q <= WRITE_I;
            end
          end
          WRITE_I: begin
            addr_q  <= j_q;
            wdata_q <= si_q;
            we_q    <= 1'b1;
            state_q <= WRITE_J;
          end
          WRITE_J: begin
            we_q <= 1'b0;
            k_q  <= k_next_d;
            if (i_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              i_q     <= i_q + ADDR_W'(1);
              addr_q  <= i_q + ADDR_W'(1);
              state_q <= READ_I;
            end
          end
          FINISH: begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Directed bench for rc4_ksa_engine: two instances (read latency 1 and 3) each with its own S-box RAM model.
module tb_rc4_ksa_engine;
  localparam int DW = 8, AW = 8, MK = 16, LW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, start3;
  logic [MK*DW-1:0] key;
  logic [LW-1:0]    key_len;
  logic busy, done, ram_we, busy3, done3, we3;
  logic [AW-1:0] ram_addr, addr3;
  logic [DW-1:0] ram_wdata, ram_rdata, wdata3, rdata3;

  rc4_ksa_engine #(.RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .key(key), .key_len(key_len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata));

  rc4_ksa_engine #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort), .key(key), .key_len(key_len),
    .busy(busy3), .done(done3), .ram_addr(addr3), .ram_wdata(wdata3), .ram_we(we3),
    .ram_rdata(rdata3));

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] rd1_q;
  logic [7:0] rd3_q [3];
  logic init1, init3;
  int cyc = 0, done1_cnt = 0, done3_cnt = 0;
  logic [15:0] wlog [$];

  always @(posedge clk) begin
    if (init1) for (int n = 0; n < 256; n++) mem1[n] <= 8'(n);
    else if (ram_we) mem1[ram_addr] <= ram_wdata;
    rd1_q <= mem1[ram_addr];
    if (init3) for (int n = 0; n < 256; n++) mem3[n] <= 8'(n);
    else if (we3) mem3[addr3] <= wdata3;
    rd3_q[0] <= mem3[addr3];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
    cyc <= cyc + 1;
    if (done)  done1_cnt <= done1_cnt + 1;
    if (done3) done3_cnt <= done3_cnt + 1;
    if (ram_we) wlog.push_back({ram_addr, ram_wdata});
  end
  assign ram_rdata = rd1_q;
  assign rdata3    = rd3_q[2];

  int checks = 0, errors = 0;
  logic [7:0] gold [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference KSA over an identity S-box.
  task automatic compute_gold(input logic [MK*DW-1:0] k, input int len);
    logic [7:0] s [256];
    logic [7:0] j, t;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      j = j + s[i] + k[(i % len)*8 +: 8];
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    gold = s;
  endtask

  function automatic int mism1();
    int m = 0;
    for (int n = 0; n < 256; n++) if (mem1[n] !== gold[n]) m++;
    return m;
  endfunction

  function automatic int mism3();
    int m = 0;
    for (int n = 0; n < 256; n++) if (mem3[n] !== gold[n]) m++;
    return m;
  endfunction

  task automatic reinit1();
    init1 = 1'b1;
    @(negedge clk);
    init1 = 1'b0;
  endtask

  task automatic pulse1();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for busy, then for done; returns cycles from first busy cycle to the done cycle.
  task automatic run_wait(input bit sel, input string tag, output int dur);
    int n, t0, bad;
    n = 0;
    while ((sel ? busy3 : busy) !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, " busy rises"}, 32'(sel ? busy3 : busy), 1);
    t0 = cyc; bad = 0; n = 0;
    while ((sel ? done3 : done) !== 1'b1 && n < 4000) begin
      if ((sel ? busy3 : busy) !== 1'b1) bad++;
      @(negedge clk); n++;
    end
    check({tag, " done seen"}, 32'(sel ? done3 : done), 1);
    check({tag, " busy held"}, bad, 0);
    dur = cyc - t0;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] v;
    v = (idx < wlog.size()) ? wlog[idx] : 16'hxxxx;
    check(tag, 32'(v), 32'(exp));
  endtask

  int dur, base, dc, t0, n;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0;
    key = '0; key_len = '0; init1 = 1'b1; init3 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", {busy, done, ram_we, ram_addr, ram_wdata}, 0);
    check("reset outputs dut3", {busy3, done3, we3, addr3, wdata3}, 0);
    reset = 1'b0; init1 = 1'b0; init3 = 1'b0;

    // Key 03 5F 3C, latency 1
    key[7:0] = 8'h03; key[15:8] = 8'h5F; key[23:16] = 8'h3C; key_len = 3;
    compute_gold(key, 3);
    base = wlog.size();
    pulse1();
    run_wait(0, "t1", dur);
    check("t1 cycles", dur, 1536);
    repeat (3) @(negedge clk);
    check("t1 sbox mismatches", mism1(), 0);
    check("t1 done count", done1_cnt, 1);
    check_log("t1 write0", base + 0, 16'h0003);
    check_log("t1 write1", base + 1, 16'h0300);
    check_log("t1 write2", base + 2, 16'h0163);
    check_log("t1 write3", base + 3, 16'h6301);

    // Same key, latency 3
    start3 = 1'b1; @(negedge clk); start3 = 1'b0;
    run_wait(1, "t2", dur);
    check("t2 cycles", dur, 2560);
    repeat (5) @(negedge clk);
    check("t2 sbox mismatches", mism3(), 0);
    check("t2 done count", done3_cnt, 1);

    // Zero key, length 1: self-swaps at i=0 and i=1
    reinit1();
    key = '0; key_len = 1;
    compute_gold(key, 1);
    base = wlog.size();
    pulse1();
    run_wait(0, "t3", dur);
    repeat (3) @(negedge clk);
    check("t3 sbox mismatches", mism1(), 0);
    check_log("t3 write0", base + 0, 16'h0000);
    check_log("t3 write1", base + 1, 16'h0000);
    check_log("t3 write2", base + 2, 16'h0101);
    check_log("t3 write3", base + 3, 16'h0101);
    check_log("t3 write4", base + 4, 16'h0203);
    check_log("t3 write5", base + 5, 16'h0302);

    // Key length clamping
    key = 128'hA7_19_C4_5E_08_F3_62_BD_2A_91_7C_E0_4F_36_D8_15;
    compute_gold(key, 16);
    reinit1(); key_len = 0; pulse1(); run_wait(0, "t4a", dur);
    repeat (3) @(negedge clk);
    check("t4 len0 sbox mismatches", mism1(), 0);
    reinit1(); key_len = 20; pulse1(); run_wait(0, "t4b", dur);
    repeat (3) @(negedge clk);
    check("t4 len20 sbox mismatches", mism1(), 0);
    compute_gold(key, 5);
    reinit1(); key_len = 5; pulse1(); run_wait(0, "t4c", dur);
    repeat (3) @(negedge clk);
    check("t4 len5 sbox mismatches", mism1(), 0);

    // Abort in WRITE_I of iteration 10, then a clean rerun
    key = '0; key[7:0] = 8'h03; key[15:8] = 8'h5F; key[23:16] = 8'h3C; key_len = 3;
    compute_gold(key, 3);
    reinit1();
    pulse1();
    check("t5 busy", 32'(busy), 1);
    t0 = cyc; n = 0;
    while (cyc < t0 + 64 && n < 200) begin @(negedge clk); n++; end
    check("t5 WRITE_I we/addr", {ram_we, ram_addr}, {1'b1, 8'd10});
    dc = done1_cnt;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("t5 after abort busy/we/done", {busy, ram_we, done}, 0);
    repeat (20) @(negedge clk);
    check("t5 no done after abort", done1_cnt, dc);
    reinit1();
    pulse1();
    run_wait(0, "t5r", dur);
    check("t5 rerun cycles", dur, 1536);
    repeat (3) @(negedge clk);
    check("t5 rerun sbox mismatches", mism1(), 0);

    // Held start gives one run; reset mid-run kills it
    reinit1();
    dc = done1_cnt;
    start = 1'b1;
    repeat (3000) @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("t6 one done for held start", done1_cnt, dc + 1);
    check("t6 held start sbox mismatches", mism1(), 0);
    pulse1();
    check("t6 second run busy", 32'(busy), 1);
    repeat (500) @(negedge clk);
    reset = 1'b1; @(negedge clk);
    check("t6 outputs after reset", {busy, done, ram_we, ram_addr, ram_wdata}, 0);
    reset = 1'b0;
    dc = done1_cnt;
    repeat (2000) @(negedge clk);
    check("t6 no done after reset", done1_cnt, dc);
    check("t6 idle after reset", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
